processing_unit: RTL and testbench
==================================

# processing_unit

Single tap of a counter-flow systolic FIR array. The cell forwards the sample stream (`a`) one stage downstream. It accumulates the partial-sum stream (`b`) upstream, adding its fixed coefficient times the current sample. A filter instantiates N cells in a chain with one shared `enable`. The filter output is `b_out` of cell 0.

## Interface
Parameters:
- `COEFF`, default 8'sd1: signed tap weight; only the low `COEFF_W` bits are used.
- `COEFF_W`, default 8: coefficient width in bits.
- `DATA_W`, default 32: width of the sample and partial-sum paths.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset is asynchronous and active-low.
- `enable`  in  1: advance strobe; the cell updates only on edges where this is high.
- `a_in`  in  `DATA_W`: signed sample from the upstream cell or the filter input.
- `a_out`  out  `DATA_W`: registered sample to the downstream cell.
- `b_in`  in  `DATA_W`: signed partial sum from the downstream cell; the last cell ties it to 0.
- `b_out`  out  `DATA_W`: registered partial sum to the upstream cell.

## Operation
- On a rising `clk` edge with `enable`=1:
  - `a_out` <= `a_in`
  - `b_out` <= `b_in` + `COEFF`·`a_in`
- On a rising `clk` edge with `enable`=0: both registers hold their values.
- Arithmetic is two's complement throughout:
  - `COEFF` is sign-extended to `DATA_W` before the multiply.
  - The product is truncated to the low `DATA_W` bits.
  - The sum wraps modulo 2^`DATA_W`.
  - There is no saturation and no overflow flag.
- `COEFF`=0 is legal: `b_out` <= `b_in`, which makes the cell a pure delay for both streams.
- The data path is purely combinational from the inputs to the register D pins. There is no internal state besides the two output registers.

## Timing
- Reset: while `rst_n`=0, `a_out`=0 and `b_out`=0. Both clear immediately and asynchronously, independent of `clk`.
- Release of `rst_n` is synchronised externally; the first update is the first enabled edge after release.
- Latency: exactly one enabled edge from `a_in`/`b_in` to `a_out`/`b_out`. Disabled edges add no latency.
- `a_in`, `b_in` and `enable` must be stable around the `clk` edge. Outputs change only on an enabled edge or on reset.
- Reset asserted mid-stream discards in-flight data. There is no pending state to flush.
- `enable` asserted while `rst_n`=0: reset wins and the outputs stay 0.
- The controller drives `enable` high for two consecutive cycles per input sample and holds the filter input constant across both cycles.
- Combinational path: `a_in` → multiply → add → `b_out` D pin. This must close at the target clock for `DATA_W`=32, `COEFF_W`=8.

## Structure
- Shared package `fir_pkg`:
  - `DATA_W`=32 and `COEFF_W`=8 defaults.
  - Typedefs `sample_t` (signed `DATA_W`) and `coeff_t` (signed `COEFF_W`).
  - Coefficient-table constants used by the top-level filter.
- Single natural sub-module `signed_mac`: combinational `b_in` + sext(`COEFF`)·`a_in`, truncated to `DATA_W`. `processing_unit` wraps it with the two enabled registers.
- A chain wrapper (the filter) is out of scope.

## Test plan
- Reset:
  - Drive `a_in`=5, `b_in`=10, `enable`=1, `rst_n`=0 over several edges → `a_out`=0, `b_out`=0.
  - Assert `rst_n` low between edges → both outputs go to 0 before the next edge.
- Basic MAC: `COEFF`=3, `a_in`=5, `b_in`=10, `enable`=1, one edge → `a_out`=5, `b_out`=25.
- Negative operands: `COEFF`=-1, `a_in`=-7 (0xFFFFFFF9), `b_in`=0 → `b_out`=7.
  - Then `COEFF`=21, `a_in`=-2, `b_in`=100 → `b_out`=58.
- Hold: after the basic MAC, set `enable`=0, `a_in`=99, `b_in`=99 for 3 edges → `a_out`=5, `b_out`=25 unchanged.
  - Re-enable for one edge → `a_out`=99, `b_out`=99+3·99=396.
- Wrap: `COEFF`=2, `a_in`=0x7FFFFFFF, `b_in`=0 → `b_out`=0xFFFFFFFE.
  - `COEFF`=1, `a_in`=1, `b_in`=0x7FFFFFFF → `b_out`=0x80000000.
- Two-cell chain: coeffs {1,2}, last `b_in`=0, `enable` pattern two-high/one-low.
  - Input impulse 1 for two enabled edges, then 0.
  - Cell-0 `b_out` sequence follows the counter-flow recurrence with the tap values 1 and 2 appearing.
  - A scoreboard model of the recurrence matches the result exactly.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and constants for the counter-flow systolic FIR.
// Default widths, sample/coefficient types, tap table.
package fir_pkg;

  localparam int DATA_W  = 32;
  localparam int COEFF_W = 8;

  typedef logic signed [DATA_W-1:0]  sample_t;
  typedef logic signed [COEFF_W-1:0] coeff_t;

  localparam int N_TAPS = 2;

  localparam coeff_t TAPS [N_TAPS] = '{
    8'sd1,
    8'sd2
  };

endpackage

// File: rtl/signed_mac.sv
// Combinational b + sext(COEFF) * a, wrapped to DATA_W bits.
// Two's complement throughout; no saturation.
module signed_mac
  import fir_pkg::*;
#(
  parameter int DATA_W  = fir_pkg::DATA_W,
  parameter int COEFF_W = fir_pkg::COEFF_W,
  parameter logic signed [COEFF_W-1:0] COEFF = 8'sd1
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] y
);

  localparam logic signed [DATA_W-1:0] C_EXT =
    DATA_W'(COEFF);

  logic signed [DATA_W-1:0] prod;

  // low DATA_W bits of the product are sign-agnostic
  assign prod = a * C_EXT;
  assign y    = b + prod;

endmodule

// File: rtl/processing_unit.sv
// One tap of a counter-flow systolic FIR: sample flows down,
// partial sum flows up through a registered MAC.
module processing_unit
  import fir_pkg::*;
#(
  parameter int DATA_W  = fir_pkg::DATA_W,
  parameter int COEFF_W = fir_pkg::COEFF_W,
  parameter logic signed [COEFF_W-1:0] COEFF = 8'sd1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] a_in,
  output logic signed [DATA_W-1:0] a_out,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] b_out
);

  logic signed [DATA_W-1:0] b_next;

  signed_mac #(
    .DATA_W (DATA_W),
    .COEFF_W(COEFF_W),
    .COEFF  (COEFF)
  ) u_mac (
    .a(a_in),
    .b(b_in),
    .y(b_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
    end else if (enable) begin
      a_out <= a_in;
      b_out <= b_next;
    end
  end

endmodule

// File: tb/tb_processing_unit.sv
// Self-checking bench: per-coefficient vector table, hold,
// reset and a two-cell counter-flow chain against a model.
module tb_processing_unit;

  localparam int NI = 6;

  function automatic logic signed [7:0] cof(input int i);
    case (i)
      0:       return 8'sd3;
      1:       return -8'sd1;
      2:       return 8'sd21;
      3:       return 8'sd2;
      4:       return 8'sd1;
      default: return 8'sd0;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic signed [31:0] a_in  [NI];
  logic signed [31:0] b_in  [NI];
  logic signed [31:0] a_out [NI];
  logic signed [31:0] b_out [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    processing_unit #(
      .DATA_W (32),
      .COEFF_W(8),
      .COEFF  (cof(g))
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .enable(enable),
      .a_in  (a_in[g]),
      .a_out (a_out[g]),
      .b_in  (b_in[g]),
      .b_out (b_out[g])
    );
  end

  logic ch_en = 1'b0;
  logic signed [31:0] ch_x = '0;
  logic signed [31:0] c0_a, c0_b, c1_a, c1_b;

  processing_unit #(
    .DATA_W(32), .COEFF_W(8), .COEFF(8'sd1)
  ) u_c0 (
    .clk(clk), .rst_n(rst_n), .enable(ch_en),
    .a_in(ch_x), .a_out(c0_a),
    .b_in(c1_b), .b_out(c0_b)
  );

  processing_unit #(
    .DATA_W(32), .COEFF_W(8), .COEFF(8'sd2)
  ) u_c1 (
    .clk(clk), .rst_n(rst_n), .enable(ch_en),
    .a_in(c0_a), .a_out(c1_a),
    .b_in(32'sd0), .b_out(c1_b)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] ea;
    logic [31:0] eb;
  } exp_t;

  vec_t vecs [7];
  exp_t sb [$];

  initial begin
    exp_t e;
    logic signed [31:0] m_a0, m_b0, m_a1, m_b1;
    logic signed [31:0] n_a0, n_b0, n_a1, n_b1;
    logic signed [31:0] qb [$];
    int nen;

    vecs[0] = '{"mac",    0, 32'd5, 32'd10, 32'd5, 32'd25};
    vecs[1] = '{"neg1",   1, 32'hFFFFFFF9, 32'd0,
                32'hFFFFFFF9, 32'd7};
    vecs[2] = '{"neg21",  2, 32'hFFFFFFFE, 32'd100,
                32'hFFFFFFFE, 32'd58};
    vecs[3] = '{"wrap2",  3, 32'h7FFFFFFF, 32'd0,
                32'h7FFFFFFF, 32'hFFFFFFFE};
    vecs[4] = '{"wrap1",  4, 32'd1, 32'h7FFFFFFF,
                32'd1, 32'h80000000};
    vecs[5] = '{"zero",   5, 32'd123, 32'd456,
                32'd123, 32'd456};
    vecs[6] = '{"mac2",   0, 32'hFFFFFFFF, 32'd7,
                32'hFFFFFFFF, 32'd4};

    for (int i = 0; i < NI; i++) begin
      a_in[i] = 32'sd5;
      b_in[i] = 32'sd10;
    end

    // reset held with enable high
    rst_n = 1'b0;
    enable = 1'b1;
    repeat (3) begin
      step();
      chk("rst_a", a_out[0], 32'd0);
      chk("rst_b", b_out[0], 32'd0);
    end
    chk("rst_c0b", c0_b, 32'd0);
    rst_n = 1'b1;
    enable = 1'b0;
    step();

    foreach (vecs[k]) begin
      a_in[vecs[k].sel] = vecs[k].a;
      b_in[vecs[k].sel] = vecs[k].b;
      enable = 1'b1;
      sb.push_back('{vecs[k].name, vecs[k].sel,
                     vecs[k].ea, vecs[k].eb});
      step();
      e = sb.pop_front();
      chk({e.name, "_a"}, a_out[e.sel], e.ea);
      chk({e.name, "_b"}, b_out[e.sel], e.eb);
    end

    // basic MAC again, then hold
    a_in[0] = 32'sd5;
    b_in[0] = 32'sd10;
    step();
    chk("mac_a", a_out[0], 32'd5);
    chk("mac_b", b_out[0], 32'd25);
    enable = 1'b0;
    a_in[0] = 32'sd99;
    b_in[0] = 32'sd99;
    repeat (3) begin
      step();
      chk("hold_a", a_out[0], 32'd5);
      chk("hold_b", b_out[0], 32'd25);
    end
    enable = 1'b1;
    step();
    chk("reen_a", a_out[0], 32'd99);
    chk("reen_b", b_out[0], 32'd396);
    enable = 1'b0;

    // two-cell chain, enable two-high/one-low
    m_a0 = '0; m_b0 = '0; m_a1 = '0; m_b1 = '0;
    nen = 0;
    for (int k = 0; k < 15; k++) begin
      ch_en = (k % 3) != 2;
      ch_x = (nen < 2) ? 32'sd1 : 32'sd0;
      if (ch_en) begin
        n_a0 = ch_x;
        n_b0 = m_b1 + ch_x;
        n_a1 = m_a0;
        n_b1 = 32'sd2 * m_a0;
        m_a0 = n_a0; m_b0 = n_b0;
        m_a1 = n_a1; m_b1 = n_b1;
        nen++;
      end
      qb.push_back(m_b0);
      step();
      chk("chain_b", c0_b, qb.pop_front());
    end
    ch_en = 1'b0;

    // async reset between edges
    a_in[0] = 32'sd4;
    b_in[0] = 32'sd1;
    enable = 1'b1;
    step();
    chk("pre_b", b_out[0], 32'd13);
    #2 rst_n = 1'b0;
    #1;
    chk("async_a", a_out[0], 32'd0);
    chk("async_b", b_out[0], 32'd0);
    step();
    chk("async_hold", b_out[0], 32'd0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
